tlb_op_seq: RTL
===============

// Module: tlb_op_seq
// PURPOSE
//  Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR. Accepts one TLB op from the commit stage,
//  snapshots CP0 Index/Random/EntryHi/EntryLo0/EntryLo1/PageMask, and drives the
//  single-port TLB entry array. It returns results through the CP0 tlbr/tlbp/tlbwr strobes.
//  TLBP scans one entry per cycle, so the array needs no N-way comparator.
//  The pipeline holds the issuing instruction until done, then refetches.
// PARAMETERS
//  TLB_ENTRIES   32   number of TLB entries
//  TLB_IDXBITS   5    log2(TLB_ENTRIES)
// PORTS
//  clk          in   1    clock
//  resetn       in   1    synchronous active-low reset
//  req_valid    in   1    op request from commit stage
//  req_op       in   2    0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
//  req_ready    out  1    high only in IDLE
//  done         out  1    1-cycle pulse: op complete
//  cp0_index    in   32   CP0 Index
//  cp0_random   in   32   CP0 Random
//  cp0_entryhi  in   32   CP0 EntryHi {vpn2[31:13],asid[7:0]}
//  cp0_entrylo0 in   32   CP0 EntryLo0 {pfn[25:6],c[5:3],d,v,g}
//  cp0_entrylo1 in   32   CP0 EntryLo1
//  cp0_mask     in   12   PageMask.Mask
//  tlbr         out  1    CP0 load strobe: tlbr_lo0/lo1/hi/mask valid
//  tlbr_lo0     out  32   read result, EntryLo0 format (g = entry g)
//  tlbr_lo1     out  32   read result, EntryLo1 format
//  tlbr_hi      out  32   read result, EntryHi format
//  tlbr_mask    out  12   read result, mask
//  tlbp         out  1    CP0 Index load strobe
//  tlbp_index   out  32   {P,26'b0,idx}
//  tlbwr        out  1    CP0 Random advance strobe (TLBWR write cycle only)
//  tlb_addr     out  IDX  array address
//  tlb_we       out  1    array write enable
//  tlb_wdata    out  92   entry {vpn2,asid,mask,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}
//  tlb_rdata    in   92   entry read data, registered 1 cycle after tlb_addr
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; done/tlbr/tlbp/tlbwr/tlb_we=0; counters 0.
//  Accept on req_valid&&req_ready; CP0 inputs are snapshotted on the same edge.
//  Later CP0 changes do not affect the in-flight op.
//  States: IDLE, SCAN, READ, RDATA, WRITE.
//  TLBWI/TLBWR: IDLE->WRITE. WRITE has tlb_we=1, done=1, then ->IDLE.
//   Address = index[IDX-1:0] for TLBWI, random[IDX-1:0] for TLBWR. tlbwr=1 only for TLBWR.
//   wdata: vpn2/asid from EntryHi; mask; g = lo0.g & lo1.g; pfn/c/d/v from each lo.
//  TLBR: IDLE->READ (addr=index) ->RDATA. RDATA has tlbr=1, done=1, then ->IDLE.
//   tlbr_hi = {vpn2,5'b0,asid}; tlbr_lo* upper 6 bits are 0.
//  TLBP: IDLE->SCAN. Cycle j of SCAN issues addr j and compares rdata of entry j-1.
//   match = ((e.vpn2^hi.vpn2) & ~{7'b0,e.mask})==0 && (e.g || e.asid==hi.asid).
//   On the first hit, tlbp=1, done=1, tlbp_index=hit idx, ->IDLE.
//   Multiple hits: the lowest index wins.
//   Miss after entry N-1 compared: tlbp=1, done=1, tlbp_index=32'h80000000.
//  Latency from accept edge: write 1 cycle, TLBR 2 cycles.
//   TLBP hit at entry k: k+2 cycles. TLBP miss: N+1 cycles.
//  The scan counter does not wrap; the compare of entry N-1 is terminal.
//  Strobes are combinational from state and pulse for exactly 1 cycle; they never overlap.
//  req_valid while busy is ignored (not accepted). Reset mid-op: IDLE next cycle, no strobes.
// STRUCTURE
//  common.vh: op encodings, TLB_ENTRIES/TLB_IDXBITS, entry field offsets/width (92).
//  Sub-module tlb_match: combinational entry-vs-EntryHi compare, shared with the MMU lookup.
// TESTING
//  TLBWI idx=3, hi=0x00402005, lo0=0x00001017, lo1=0x00001057, mask=0
//   -> 1 cycle: we@3, vpn2=0x201, asid=5, g=1, done.
//  TLBR idx=3 after the above -> tlbr+done at cycle 2; hi=0x00402005, lo0=0x00001017.
//  TLBP hi=0x00402005, entry 3 only valid match -> tlbp at cycle 5, tlbp_index=3.
//  TLBP hi=0x7FFFE0FF, no match in 32 entries -> tlbp at cycle 33, tlbp_index=0x80000000.
//  TLBWR random=31 -> we@31, tlbwr=1 same cycle; entry g=1/asid 9 vs hi asid 5 -> TLBP hits.
//  resetn=0 at SCAN cycle 4 -> no tlbp/done; req_ready=1 next cycle; new TLBR accepted.

Source files
------------

// File: rtl/tlb_op_seq_pkg.sv
// Shared definitions for the TLB op sequencer: op encodings, FSM states,
// TLB geometry and the 92-bit entry layout stored in the TLB array.
// Entry layout (MSB first):
//   rsvd[1:0], vpn2[18:0], asid[7:0], mask[11:0], g,
//   pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1
// The named fields add up to 90 bits. The top two bits pad the entry to the
// 92-bit array word and are always written as zero.
package tlb_op_seq_pkg;

    localparam int TLB_ENTRIES = 32;
    localparam int TLB_IDXBITS = 5;
    localparam int ENTRY_W     = 92;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_READ  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WRITE = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [1:0]  rsvd;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // Build an array entry from the CP0 fields.
    // The entry is global only when both EntryLo halves are global.
    function automatic tlb_entry_t pack_entry(
        input logic [18:0] vpn2,
        input logic [7:0]  asid,
        input logic [25:0] lo0,
        input logic [25:0] lo1,
        input logic [11:0] mask
    );
        tlb_entry_t e;
        e.rsvd = 2'b00;
        e.vpn2 = vpn2;
        e.asid = asid;
        e.mask = mask;
        e.g    = lo0[0] & lo1[0];
        e.pfn0 = lo0[25:6];
        e.c0   = lo0[5:3];
        e.d0   = lo0[2];
        e.v0   = lo0[1];
        e.pfn1 = lo1[25:6];
        e.c1   = lo1[5:3];
        e.d1   = lo1[2];
        e.v1   = lo1[1];
        return e;
    endfunction

endpackage

// File: rtl/tlb_op_seq_match.sv
// Combinational compare of one TLB entry against an EntryHi value. The MMU
// lookup path uses the same logic.
// Ports:
//   e_vpn2, e_asid, e_mask, e_g : fields of the stored entry
//   hi_vpn2, hi_asid            : EntryHi fields being probed
//   hit                         : entry matches
module tlb_op_seq_match
    import tlb_op_seq_pkg::*;
(
    input  logic [18:0] e_vpn2,
    input  logic [7:0]  e_asid,
    input  logic [11:0] e_mask,
    input  logic        e_g,
    input  logic [18:0] hi_vpn2,
    input  logic [7:0]  hi_asid,
    output logic        hit
);

    logic [18:0] vpn_diff_s;

    // Masked VPN2 compare, then the ASID check (skipped for global entries).
    always_comb begin
        vpn_diff_s = (e_vpn2 ^ hi_vpn2) & ~{7'b0000000, e_mask};
        hit        = (vpn_diff_s == 19'd0) && (e_g || (e_asid == hi_asid));
    end

endmodule

// File: rtl/tlb_op_seq.sv
// Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR. On accept it snapshots the
// CP0 registers and then drives the single-port TLB array. TLBP walks the
// array one entry per cycle. The CP0 load strobes (tlbr/tlbp/tlbwr) and done
// are decoded from the state and pulse for one cycle.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   req_valid/req_op/req_ready : op handshake from commit (ready only in IDLE)
//   done                   : op-complete pulse
//   cp0_*                  : CP0 Index/Random/EntryHi/EntryLo0/EntryLo1/PageMask
//   tlbr, tlbr_*           : TLBR result load into CP0
//   tlbp, tlbp_index       : TLBP result load into CP0 Index
//   tlbwr                  : Random advance strobe on the TLBWR write cycle
//   tlb_addr/we/wdata/rdata: TLB array port (rdata is one cycle after addr)
module tlb_op_seq
    import tlb_op_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    output logic                   req_ready,
    output logic                   done,
    input  logic [31:0]            cp0_index,
    input  logic [31:0]            cp0_random,
    input  logic [31:0]            cp0_entryhi,
    input  logic [31:0]            cp0_entrylo0,
    input  logic [31:0]            cp0_entrylo1,
    input  logic [11:0]            cp0_mask,
    output logic                   tlbr,
    output logic [31:0]            tlbr_lo0,
    output logic [31:0]            tlbr_lo1,
    output logic [31:0]            tlbr_hi,
    output logic [11:0]            tlbr_mask,
    output logic                   tlbp,
    output logic [31:0]            tlbp_index,
    output logic                   tlbwr,
    output logic [TLB_IDXBITS-1:0] tlb_addr,
    output logic                   tlb_we,
    output logic [ENTRY_W-1:0]     tlb_wdata,
    input  logic [ENTRY_W-1:0]     tlb_rdata
);

    localparam int CNT_W = TLB_IDXBITS + 1;

    seq_state_e             state_r;
    logic [CNT_W-1:0]       scan_cnt_r;
    logic [TLB_IDXBITS-1:0] addr_r;
    logic                   is_wr_r;
    tlb_entry_t             snap_r;

    tlb_entry_t             rd_s;
    logic                   hit_s;
    logic                   scan_cmp_s;
    logic                   scan_done_s;
    logic [TLB_IDXBITS-1:0] hit_idx_s;
    logic                   unused_bits;

    assign rd_s      = tlb_rdata;
    assign tlb_wdata = snap_r;
    assign unused_bits = ^{cp0_index[31:TLB_IDXBITS], cp0_random[31:TLB_IDXBITS],
                           cp0_entryhi[12:8], cp0_entrylo0[31:26],
                           cp0_entrylo1[31:26], rd_s.rsvd};

    // The snapshotted EntryHi is compared with the entry read back in the previous cycle.
    tlb_op_seq_match u_match (
        .e_vpn2  (rd_s.vpn2),
        .e_asid  (rd_s.asid),
        .e_mask  (rd_s.mask),
        .e_g     (rd_s.g),
        .hi_vpn2 (snap_r.vpn2),
        .hi_asid (snap_r.asid),
        .hit     (hit_s)
    );

    // Scan bookkeeping. Count 0 only issues address 0, so compares start at
    // count 1, and count TLB_ENTRIES is the last (compare-only) step.
    always_comb begin
        scan_cmp_s  = (state_r == ST_SCAN) && (scan_cnt_r != {CNT_W{1'b0}});
        scan_done_s = scan_cmp_s && (hit_s || (scan_cnt_r == CNT_W'(TLB_ENTRIES)));
        hit_idx_s   = scan_cnt_r[TLB_IDXBITS-1:0] - TLB_IDXBITS'(1);
    end

    // Sequencer FSM: snapshot on accept, then step through the op's states.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            scan_cnt_r <= {CNT_W{1'b0}};
            addr_r     <= {TLB_IDXBITS{1'b0}};
            is_wr_r    <= 1'b0;
            snap_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        snap_r     <= pack_entry(cp0_entryhi[31:13], cp0_entryhi[7:0],
                                                 cp0_entrylo0[25:0], cp0_entrylo1[25:0],
                                                 cp0_mask);
                        addr_r     <= (req_op == OP_TLBWR) ? cp0_random[TLB_IDXBITS-1:0]
                                                           : cp0_index[TLB_IDXBITS-1:0];
                        is_wr_r    <= (req_op == OP_TLBWR);
                        scan_cnt_r <= {CNT_W{1'b0}};
                        case (req_op)
                            OP_TLBP: state_r <= ST_SCAN;
                            OP_TLBR: state_r <= ST_READ;
                            default: state_r <= ST_WRITE;
                        endcase
                    end
                end
                ST_SCAN: begin
                    if (scan_done_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        scan_cnt_r <= scan_cnt_r + CNT_W'(1);
                    end
                end
                ST_READ:  state_r <= ST_RDATA;
                ST_RDATA: state_r <= ST_IDLE;
                ST_WRITE: state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Array address and the state-decoded strobes. A low resetn suppresses the strobes.
    always_comb begin
        case (state_r)
            ST_SCAN:           tlb_addr = scan_cnt_r[TLB_IDXBITS-1:0];
            ST_READ, ST_WRITE: tlb_addr = addr_r;
            default:           tlb_addr = {TLB_IDXBITS{1'b0}};
        endcase
        req_ready  = (state_r == ST_IDLE);
        tlb_we     = resetn && (state_r == ST_WRITE);
        tlbwr      = resetn && (state_r == ST_WRITE) && is_wr_r;
        tlbr       = resetn && (state_r == ST_RDATA);
        tlbp       = resetn && scan_done_s;
        done       = tlb_we || tlbr || tlbp;
        tlbp_index = hit_s ? {{(32-TLB_IDXBITS){1'b0}}, hit_idx_s} : 32'h8000_0000;
        tlbr_hi    = {rd_s.vpn2, 5'b00000, rd_s.asid};
        tlbr_lo0   = {6'b000000, rd_s.pfn0, rd_s.c0, rd_s.d0, rd_s.v0, rd_s.g};
        tlbr_lo1   = {6'b000000, rd_s.pfn1, rd_s.c1, rd_s.d1, rd_s.v1, rd_s.g};
        tlbr_mask  = rd_s.mask;
    end

endmodule
